// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: state encoding, default
// sizing and the fixed-priority encoder used for irq_top.
package irq_pkg;

    localparam int NUM_SRC_DEF     = 8;
    localparam int HOLDOFF_DEF     = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } irqState_e;

    // Lowest-numbered set bit wins; an empty vector encodes as 0.
    function automatic logic [2:0] prioEncode(input logic [7:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-stage synchronizer for the raw interrupt lines plus a rising-edge
// detector on the synchronized value.
module irq_sync
    import irq_pkg::*;
#(
    parameter int WIDTH  = NUM_SRC_DEF,
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] hist_q;
    logic [STAGES:0]  warm_q;

    // Edges are ignored until the chain has refilled after reset, so a line
    // already high at release becomes the baseline instead of a new event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
            hist_q <= '0;
            warm_q <= '0;
        end else begin
            stage_q[0] <= async_i;
            for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
            hist_q <= stage_q[STAGES-1];
            warm_q <= {warm_q[STAGES-1:0], 1'b1};
        end
    end

    assign sync_o = stage_q[STAGES-1];
    assign rise_o = stage_q[STAGES-1] & ~hist_q & {WIDTH{warm_q[STAGES]}};

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches edge/level requests into a pending vector,
// tracks overruns, and gates the summary interrupt with a quiet-time holdoff.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = NUM_SRC_DEF,
    parameter int HOLDOFF     = HOLDOFF_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [NUM_SRC-1:0] src_edge,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic [NUM_SRC-1:0] int_ack,
    output logic [NUM_SRC-1:0] int_pend,
    output logic [NUM_SRC-1:0] overrun,
    output logic               irq_any,
    output logic [2:0]         irq_top,
    output logic               busy
);

    localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    logic [NUM_SRC-1:0] syncV, riseV, setEv;
    logic [NUM_SRC-1:0] pend_q, pend_d, ovr_q, ovr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    irqState_e          state_q, state_d;
    logic               anyPend;

    irq_sync #(
        .WIDTH  (NUM_SRC),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (src_in),
        .sync_o  (syncV),
        .rise_o  (riseV)
    );

    // A set event beats a simultaneous ack; overrun only counts edge retriggers.
    always_comb begin
        setEv  = (src_edge & riseV) | (~src_edge & syncV);
        pend_d = setEv | (pend_q & ~int_ack);
        ovr_d  = (ovr_q | (src_edge & riseV & pend_q)) & ~int_ack;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign int_pend = pend_q & src_mask;
    assign overrun  = ovr_q;
    assign anyPend  = |int_pend;
    assign irq_top  = prioEncode(int_pend);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (anyPend) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!anyPend) begin
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) state_d = anyPend ? ST_ACTIVE : ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_any = (state_q == ST_ACTIVE) && anyPend;
        busy    = (state_q != ST_IDLE);
    end

endmodule
